// File: rtl/cache_request_sequencer.sv
// ============================================================================
//  Module      : cache_request_sequencer
//  Description : Issues NUM_REQ strided cache addresses to the controller and
//                counts hits/misses as each request is decoded.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_request_sequencer #(
    parameter int                ADDR_W     = 15,
    parameter int                CNT_W      = 16,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                STRIDE     = 1,
    parameter int                NUM_REQ    = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              ready,
    input  logic              hit,
    input  logic              cache_read,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam logic [ADDR_W-1:0] c_STRIDE  = ADDR_W'(STRIDE);
    localparam logic [CNT_W-1:0]  c_NUM_REQ = CNT_W'(NUM_REQ);
    localparam logic [CNT_W-1:0]  c_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_address;
    logic [CNT_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  r_hit_count;
    logic [CNT_W-1:0]  r_miss_count;
    logic              r_busy;
    logic              r_done;

    always_ff @(posedge clk) begin
        if (!clear) begin
            r_state      <= S_IDLE;
            r_address    <= '0;
            r_remaining  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_address    <= START_ADDR;
                        r_remaining  <= c_NUM_REQ;
                        r_hit_count  <= '0;
                        r_miss_count <= '0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A transaction already in flight at start time is skipped:
                    // only a fresh DECODE (ready) is accepted and counted here.
                    if (ready) begin
                        if (hit) begin
                            r_hit_count <= r_hit_count + c_ONE;
                        end else begin
                            r_miss_count <= r_miss_count + c_ONE;
                        end
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cache_read) begin
                        r_remaining <= r_remaining - c_ONE;
                        if (r_remaining == c_ONE) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_address <= r_address + c_STRIDE;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign address    = r_address;
    assign busy       = r_busy;
    assign done       = r_done;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule

`default_nettype wire

// File: tb/tb_cache_request_sequencer.sv
// ============================================================================
//  Module      : tb_cache_request_sequencer
//  Description : Drives two sequencers (different start addresses) from a
//                DECODE->[WRITE]->READ controller model; scoreboarded checks.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_request_sequencer;

    localparam int ADDR_W = 15;
    localparam int CNT_W  = 16;
    localparam int NREQ   = 4;
    localparam logic [ADDR_W-1:0] c_START_A = 15'h0010;
    localparam logic [ADDR_W-1:0] c_START_B = 15'h7FFE;

    logic              clk = 1'b0;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic              ready = 1'b0;
    logic              hit = 1'b0;
    logic              cache_read = 1'b0;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic              busy_a, busy_b, done_a, done_b;
    logic [CNT_W-1:0]  hcnt_a, hcnt_b, mcnt_a, mcnt_b;

    always #5 clk = ~clk;

    cache_request_sequencer #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .START_ADDR(c_START_A), .STRIDE(1), .NUM_REQ(NREQ)
    ) dut_a (
        .clk(clk), .clear(clear), .start(start), .ready(ready), .hit(hit),
        .cache_read(cache_read), .address(addr_a), .busy(busy_a), .done(done_a),
        .hit_count(hcnt_a), .miss_count(mcnt_a)
    );

    cache_request_sequencer #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .START_ADDR(c_START_B), .STRIDE(1), .NUM_REQ(NREQ)
    ) dut_b (
        .clk(clk), .clear(clear), .start(start), .ready(ready), .hit(hit),
        .cache_read(cache_read), .address(addr_b), .busy(busy_b), .done(done_b),
        .hit_count(hcnt_b), .miss_count(mcnt_b)
    );

    int unsigned       cyc = 0;
    int                n_checks = 0;
    int                n_pass = 0;
    logic [ADDR_W-1:0] qa[$];
    logic [ADDR_W-1:0] qb[$];
    int                exp_hit, exp_miss;
    logic [ADDR_W-1:0] last_a, last_b;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse start for one edge, queue the expected address sequence of the run.
    task automatic start_run();
        logic [ADDR_W-1:0] a, b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
        a = c_START_A;
        b = c_START_B;
        for (int i = 0; i < NREQ; i++) begin
            qa.push_back(a);
            qb.push_back(b);
            a = a + 15'd1;
            b = b + 15'd1;
        end
        n_checks++;
        if (busy_a !== 1'b1 || done_a !== 1'b0 || hcnt_a !== '0 || mcnt_a !== '0)
            $display("FAIL start_state: busy=%b done=%b hit=%0d miss=%0d, required 1 0 0 0",
                     busy_a, done_a, hcnt_a, mcnt_a);
        else n_pass++;
    endtask

    // One controller transaction: DECODE, WRITE on a miss, READ.
    task automatic do_txn(input bit h);
        logic [ADDR_W-1:0] ea, eb;
        ea = 'x;
        eb = 'x;
        if (qa.size() > 0) ea = qa.pop_front();
        if (qb.size() > 0) eb = qb.pop_front();
        last_a = ea;
        last_b = eb;
        ready = 1'b1;
        hit = h;
        n_checks++;
        if (addr_a !== ea || addr_b !== eb)
            $display("FAIL decode_addr: got a=%h b=%h, required a=%h b=%h", addr_a, addr_b, ea, eb);
        else n_pass++;
        @(negedge clk);
        ready = 1'b0;
        hit = 1'b0;
        if (h) exp_hit++; else exp_miss++;
        n_checks++;
        if (hcnt_a !== CNT_W'(exp_hit) || mcnt_a !== CNT_W'(exp_miss) ||
            hcnt_b !== CNT_W'(exp_hit) || mcnt_b !== CNT_W'(exp_miss))
            $display("FAIL accept_counts: got hit=%0d miss=%0d, required hit=%0d miss=%0d",
                     hcnt_a, mcnt_a, exp_hit, exp_miss);
        else n_pass++;
        if (!h) begin
            n_checks++;
            if (addr_a !== ea || addr_b !== eb)
                $display("FAIL write_addr_stable: got a=%h b=%h, required a=%h b=%h", addr_a, addr_b, ea, eb);
            else n_pass++;
            @(negedge clk);
        end
        cache_read = 1'b1;
        n_checks++;
        if (addr_a !== ea || addr_b !== eb || done_a !== 1'b0 || busy_a !== 1'b1)
            $display("FAIL read_phase: got a=%h b=%h done=%b busy=%b, required a=%h b=%h done=0 busy=1",
                     addr_a, addr_b, done_a, busy_a, ea, eb);
        else n_pass++;
        @(negedge clk);
        cache_read = 1'b0;
    endtask

    task automatic check_run_end(input string name, input int unsigned t0, input int unsigned cycles);
        n_checks++;
        if (done_a !== 1'b1 || done_b !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0)
            $display("FAIL %s_done: got done=%b%b busy=%b%b, required done=11 busy=00",
                     name, done_a, done_b, busy_a, busy_b);
        else n_pass++;
        n_checks++;
        if (cyc - t0 !== cycles)
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, cyc - t0, cycles);
        else n_pass++;
        n_checks++;
        if (hcnt_a !== CNT_W'(exp_hit) || mcnt_a !== CNT_W'(exp_miss) ||
            32'(hcnt_a) + 32'(mcnt_a) !== NREQ)
            $display("FAIL %s_counts: got hit=%0d miss=%0d, required hit=%0d miss=%0d",
                     name, hcnt_a, mcnt_a, exp_hit, exp_miss);
        else n_pass++;
        n_checks++;
        if (addr_a !== last_a || addr_b !== last_b)
            $display("FAIL %s_addr_held: got a=%h b=%h, required a=%h b=%h", name, addr_a, addr_b, last_a, last_b);
        else n_pass++;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (addr_a !== '0 || addr_b !== '0 || busy_a !== 1'b0 || busy_b !== 1'b0 ||
            done_a !== 1'b0 || done_b !== 1'b0 || hcnt_a !== '0 || mcnt_a !== '0 ||
            hcnt_b !== '0 || mcnt_b !== '0)
            $display("FAIL %s: got a=%h b=%h busy=%b%b done=%b%b hit=%0d miss=%0d, required all zero",
                     name, addr_a, addr_b, busy_a, busy_b, done_a, done_b, hcnt_a, mcnt_a);
        else n_pass++;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        check_all_zero("reset_state");
        clear = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_all_hits();
        int unsigned t0;
        start_run();
        t0 = cyc;
        for (int i = 0; i < NREQ; i++) do_txn(1'b1);
        check_run_end("all_hits", t0, 8);
    endtask

    task automatic test_mixed();
        int unsigned t0;
        start_run();
        t0 = cyc;
        do_txn(1'b0);
        do_txn(1'b1);
        do_txn(1'b0);
        do_txn(1'b1);
        check_run_end("mixed", t0, 10);
    endtask

    task automatic test_wrap();
        int unsigned t0;
        start_run();
        t0 = cyc;
        for (int i = 0; i < NREQ; i++) do_txn(1'b1);
        check_run_end("wrap", t0, 8);
        n_checks++;
        if (addr_b !== 15'h0001)
            $display("FAIL wrap_final_addr: got %h, required 0001", addr_b);
        else n_pass++;
    endtask

    task automatic test_start_mid_txn();
        int unsigned t0;
        ready = 1'b1;
        hit = 1'b0;
        @(negedge clk);
        ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cache_read = 1'b1;
        exp_hit = 0;
        exp_miss = 0;
        for (int i = 0; i < NREQ; i++) begin
            qa.push_back(c_START_A + 15'(i));
            qb.push_back(c_START_B + 15'(i));
        end
        @(negedge clk);
        cache_read = 1'b0;
        n_checks++;
        if (hcnt_a !== '0 || mcnt_a !== '0 || busy_a !== 1'b1 || addr_a !== c_START_A)
            $display("FAIL partial_txn_ignored: got hit=%0d miss=%0d busy=%b a=%h, required 0 0 1 %h",
                     hcnt_a, mcnt_a, busy_a, addr_a, c_START_A);
        else n_pass++;
        t0 = cyc;
        do_txn(1'b1);
        do_txn(1'b0);
        do_txn(1'b0);
        do_txn(1'b1);
        check_run_end("start_mid_txn", t0, 10);
    endtask

    task automatic test_reset_mid_run();
        int unsigned t0;
        start_run();
        do_txn(1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (hcnt_a !== 16'd1 || mcnt_a !== 16'd0 || addr_a !== qa[0] || busy_a !== 1'b1)
            $display("FAIL start_while_busy: got hit=%0d miss=%0d a=%h busy=%b, required 1 0 %h 1",
                     hcnt_a, mcnt_a, addr_a, busy_a, qa[0]);
        else n_pass++;
        do_txn(1'b0);
        ready = 1'b1;
        hit = 1'b0;
        @(negedge clk);
        ready = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        qa.delete();
        qb.delete();
        check_all_zero("reset_mid_run");
        cache_read = 1'b1;
        @(negedge clk);
        cache_read = 1'b0;
        check_all_zero("idle_ignores_read");
        start_run();
        t0 = cyc;
        do_txn(1'b1);
        do_txn(1'b1);
        do_txn(1'b0);
        do_txn(1'b0);
        check_run_end("restart", t0, 10);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_all_hits();
        test_mixed();
        test_wrap();
        test_start_mid_txn();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
